// File: rtl/mdu_seq_pkg.sv
// -----------------------------------------------------------------------------
// mdu_seq_pkg
//   Shared definitions for the multiply/divide sequencer:
//     - MDU op encodings as driven by the execute stage on req_op
//     - sequencer state encoding
//     - iteration counter width
//     - small helpers for op classification
// -----------------------------------------------------------------------------
package mdu_seq_pkg;

  localparam int MDU_OP_WD = 2;
  // Counter covers exactly 32 iterations and wraps back to 0 on exit.
  localparam int CNT_W     = 5;

  typedef enum logic [MDU_OP_WD-1:0] {
    MDU_OP_MULT  = 2'b00,
    MDU_OP_MULTU = 2'b01,
    MDU_OP_DIV   = 2'b10,
    MDU_OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } mdu_state_e;

  // Divide ops have the MSB of the encoding set.
  function automatic logic op_is_div(input logic [MDU_OP_WD-1:0] op);
    return op[1];
  endfunction

  // MULT and DIV treat operands as two's-complement.
  function automatic logic op_is_signed(input logic [MDU_OP_WD-1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  endfunction

endpackage : mdu_seq_pkg

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
//   One radix-2 iteration of the MDU datapath, purely combinational.
//
//   Multiply (shift-add), acc = {upper, multiplier/low product}:
//     if acc[0], add the multiplicand into the upper half (33-bit sum keeps
//     the carry), then shift the whole thing right by one with that carry in.
//   Divide (restoring), acc = {remainder, quotient/dividend}:
//     shift {rem, quo} left by one, trial-subtract the divisor from the
//     33-bit partial remainder; if non-negative keep it and set quotient LSB.
//
// Ports:
//   is_div  in   select divide step (1) or multiply step (0)
//   acc_i   in   current 64-bit accumulator
//   opnd_i  in   multiplicand (multiply) or divisor (divide) magnitude
//   acc_o   out  accumulator after one iteration
// -----------------------------------------------------------------------------
module mdu_iter
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_part;
  logic [WIDTH:0] div_trial;

  always_comb begin
    mul_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Remainder shifted left with the next dividend bit pulled in.
    div_part  = acc_i[2*WIDTH-1:WIDTH-1];
    // The remainder is always below the divisor, so a 33-bit difference is
    // enough: bit WIDTH is set exactly when the trial went negative.
    div_trial = div_part - {1'b0, opnd_i};

    if (is_div) begin
      if (!div_trial[WIDTH]) begin
        acc_o = {div_trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {div_part[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule : mdu_iter

// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq
//   Multi-cycle multiply/divide sequencer owning the architectural HI/LO
//   registers. Ops arrive from execute over req_valid/req_ready, iterate for
//   32 cycles (or skip straight to the finish step for zero operands when
//   FAST_ZERO is set), get sign-corrected in FIN and commit to HI/LO.
//
// Parameters:
//   WIDTH      operand width, only 32 is supported
//   FAST_ZERO  1: zero divisor / zero multiply operand completes without
//              iterating
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   op handshake; ready only while IDLE
//   req_op            00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b      rs (multiplicand/dividend), rt (multiplier/divisor)
//   flush             abort any in-flight op, HI/LO untouched
//   hi_we, lo_we      MTHI/MTLO enables, honoured only while IDLE
//   mt_wdata          MTHI/MTLO data
//   busy              sequencer not IDLE (interlock for MFHI/MFLO/MDU ops)
//   done              one-cycle pulse after an op commits HI/LO
//   hi, lo            HI/LO registers
// -----------------------------------------------------------------------------
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [MDU_OP_WD-1:0] req_op,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  input  logic                 flush,
  input  logic                 hi_we,
  input  logic                 lo_we,
  input  logic [WIDTH-1:0]     mt_wdata,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mdu_state_e         state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  mdu_op_e            op_q,       op_d;
  logic               neg_res_q,  neg_res_d;   // negate product / quotient
  logic               neg_rem_q,  neg_rem_d;   // negate remainder (dividend sign)
  logic               div_zero_q, div_zero_d;  // divide by zero, override result
  logic [WIDTH-1:0]   a_raw_q,    a_raw_d;     // raw dividend for div-by-zero HI
  logic [WIDTH-1:0]   mag_a_q,    mag_a_d;
  logic [WIDTH-1:0]   mag_b_q,    mag_b_d;
  logic [2*WIDTH-1:0] acc_q,      acc_d;
  logic [WIDTH-1:0]   hi_q,       hi_d;
  logic [WIDTH-1:0]   lo_q,       lo_d;
  logic               done_q,     done_d;

  // ---------------------------------------------------------------------------
  // Request decode (only consumed in IDLE)
  // ---------------------------------------------------------------------------
  logic               req_signed;
  logic               req_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic               fast_zero;

  always_comb begin
    req_signed = op_is_signed(req_op);
    req_div    = op_is_div(req_op);
    a_neg      = req_signed & src_a[WIDTH-1];
    b_neg      = req_signed & src_b[WIDTH-1];
    mag_a_in   = a_neg ? -src_a : src_a;
    mag_b_in   = b_neg ? -src_b : src_b;
    fast_zero  = FAST_ZERO &&
                 (req_div ? (src_b == '0) : ((src_a == '0) || (src_b == '0)));
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   iter_opnd;
  logic [2*WIDTH-1:0] acc_step;

  // Multiply adds the multiplicand (src_a); divide subtracts the divisor (src_b).
  assign iter_opnd = op_is_div(op_q) ? mag_b_q : mag_a_q;

  mdu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .is_div (op_is_div(op_q)),
    .acc_i  (acc_q),
    .opnd_i (iter_opnd),
    .acc_o  (acc_step)
  );

  // ---------------------------------------------------------------------------
  // Sign correction applied during FIN
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;

  always_comb begin
    fin_hi = '0;
    fin_lo = '0;
    case (op_q)
      MDU_OP_MULT, MDU_OP_MULTU: begin
        {fin_hi, fin_lo} = neg_res_q ? -acc_q : acc_q;
      end
      default: begin
        // 0x80000000 / -1: magnitude quotient 0x80000000 negates onto itself.
        fin_lo = neg_res_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        fin_hi = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (div_zero_q) begin
          fin_lo = '1;
          fin_hi = a_raw_q;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here is given its default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    a_raw_d    = a_raw_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // MTHI/MTLO land even when an op is accepted in the same cycle.
        if (hi_we) hi_d = mt_wdata;
        if (lo_we) lo_d = mt_wdata;

        if (req_valid) begin
          op_d       = mdu_op_e'(req_op);
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = req_div && (src_b == '0);
          a_raw_d    = src_a;
          mag_a_d    = mag_a_in;
          mag_b_d    = mag_b_in;
          cnt_d      = '0;
          // Divide starts with the dividend in the quotient half; multiply
          // starts with the multiplier in the low half.
          acc_d      = {{WIDTH{1'b0}}, (req_div ? mag_a_in : mag_b_in)};
          if (fast_zero) begin
            // A zero multiply operand means a zero product; divide-by-zero
            // is overridden in FIN regardless of the accumulator.
            acc_d   = '0;
            state_d = ST_FIN;
          end else begin
            state_d = req_div ? ST_DIV : ST_MUL;
          end
        end
      end

      ST_MUL, ST_DIV: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        hi_d    = fin_hi;
        lo_d    = fin_lo;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including the FIN commit.
    if (flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= MDU_OP_MULT;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_raw_q    <= '0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      a_raw_q    <= a_raw_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule : mdu_seq

// File: tb/tb_mdu_seq.sv
// -----------------------------------------------------------------------------
// tb_mdu_seq
//   Two sequencers (FAST_ZERO=1 and FAST_ZERO=0) share one stimulus stream.
//   A transaction-level model tracks, per instance, the expected HI/LO,
//   busy and done from plain arithmetic and a latency countdown; a single
//   compare process checks every cycle. Directed tests add literal checks.
// -----------------------------------------------------------------------------
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] mt_wdata;

  logic        f_ready, f_busy, f_done;
  logic [31:0] f_hi, f_lo;
  logic        n_ready, n_busy, n_done;
  logic [31:0] n_hi, n_lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  mdu_seq #(.WIDTH(32), .FAST_ZERO(1'b1)) dut_fz (
    .clk (clk), .reset (reset), .req_valid (req_valid), .req_ready (f_ready),
    .req_op (req_op), .src_a (src_a), .src_b (src_b), .flush (flush),
    .hi_we (hi_we), .lo_we (lo_we), .mt_wdata (mt_wdata),
    .busy (f_busy), .done (f_done), .hi (f_hi), .lo (f_lo)
  );

  mdu_seq #(.WIDTH(32), .FAST_ZERO(1'b0)) dut_nf (
    .clk (clk), .reset (reset), .req_valid (req_valid), .req_ready (n_ready),
    .req_op (req_op), .src_a (src_a), .src_b (src_b), .flush (flush),
    .hi_we (hi_we), .lo_we (lo_we), .mt_wdata (mt_wdata),
    .busy (n_busy), .done (n_done), .hi (n_hi), .lo (n_lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] model_result(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb;
    int     ia, ib;
    case (op)
      MDU_OP_MULT: begin
        sa = $signed(a);
        sb = $signed(b);
        return 64'(sa * sb);
      end
      MDU_OP_MULTU: return {32'h0, a} * {32'h0, b};
      MDU_OP_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        ia = $signed(a);
        ib = $signed(b);
        return {32'(ia % ib), 32'(ia / ib)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic bit zero_operand(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    return op[1] ? (b == 32'h0) : (a == 32'h0 || b == 32'h0);
  endfunction

  // index 0: FAST_ZERO=1 instance, index 1: FAST_ZERO=0 instance
  bit          m_busy [2];
  bit          m_done [2];
  int          m_left [2];
  logic [31:0] m_hi   [2];
  logic [31:0] m_lo   [2];
  logic [63:0] p_res  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_left[i] <= 0;
        m_hi[i]   <= 32'h0;
        m_lo[i]   <= 32'h0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_busy[i]) begin
          if (flush) begin
            m_busy[i] <= 1'b0;
          end else if (m_left[i] == 1) begin
            m_hi[i]   <= p_res[i][63:32];
            m_lo[i]   <= p_res[i][31:0];
            m_done[i] <= 1'b1;
            m_busy[i] <= 1'b0;
          end else begin
            m_left[i] <= m_left[i] - 1;
          end
        end else begin
          if (hi_we) m_hi[i] <= mt_wdata;
          if (lo_we) m_lo[i] <= mt_wdata;
          if (req_valid) begin
            m_busy[i] <= 1'b1;
            p_res[i]  <= model_result(req_op, src_a, src_b);
            m_left[i] <= (i == 0 && zero_operand(req_op, src_a, src_b)) ? 1 : 33;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare
  // ---------------------------------------------------------------------------
  task automatic cmp_inst(input int i, input logic dn, input logic bz, input logic rd,
                          input logic [31:0] h, input logic [31:0] l);
    check($sformatf("done[%0d]", i),  dn, m_done[i]);
    check($sformatf("busy[%0d]", i),  bz, m_busy[i]);
    check($sformatf("ready[%0d]", i), rd, !m_busy[i]);
    check($sformatf("hi[%0d]", i),    h,  m_hi[i]);
    check($sformatf("lo[%0d]", i),    l,  m_lo[i]);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp_inst(0, f_done, f_busy, f_ready, f_hi, f_lo);
      cmp_inst(1, n_done, n_busy, n_ready, n_hi, n_lo);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  // Called just after a negedge; the op is accepted at the next posedge
  // (edge T) and sample k is taken at the negedge inside cycle T+k.
  task automatic run_op(input int sel, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input string name, input bit mt_poke,
                        output int busy_n, output int nrdy_n);
    int k;
    logic dn, bz, rd;
    logic [31:0] h, l;
    req_valid = 1'b1;
    req_op    = op;
    src_a     = a;
    src_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    busy_n = 0;
    nrdy_n = 0;
    k = 1;
    h = 32'h0;
    l = 32'h0;
    while (k <= 60) begin
      if (sel == 0) begin dn = f_done; bz = f_busy; rd = f_ready; h = f_hi; l = f_lo; end
      else          begin dn = n_done; bz = n_busy; rd = n_ready; h = n_hi; l = n_lo; end
      if (dn) break;
      if (bz) busy_n++;
      if (!rd) nrdy_n++;
      if (mt_poke && k == 5) begin
        hi_we    = 1'b1;
        mt_wdata = 32'hDEAD_BEEF;
      end else begin
        hi_we = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    hi_we = 1'b0;
    check({name, " latency"}, k, exp_lat);
    check({name, " hi"}, h, exp_hi);
    check({name, " lo"}, l, exp_lo);
  endtask

  task automatic wait_nf_idle();
    int k;
    k = 0;
    while (n_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("nf idle wait", n_busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, rn, seen;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    src_a     = 32'h0;
    src_b     = 32'h0;
    flush     = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    mt_wdata  = 32'h0;

    repeat (3) @(negedge clk);
    check("reset hi",    f_hi,    32'h0);
    check("reset lo",    f_lo,    32'h0);
    check("reset busy",  f_busy,  1'b0);
    check("reset done",  f_done,  1'b0);
    check("reset ready", f_ready, 1'b1);
    check("reset nf hi", n_hi,    32'h0);
    reset    = 1'b0;
    check_en = 1'b1;

    run_op(0, MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001,
           "multu_max", 1'b0, bn, rn);
    check("multu_max busy cycles", bn, 33);
    check("multu_max not-ready cycles", rn, 33);

    run_op(0, MDU_OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
           "mult_neg3x7", 1'b0, bn, rn);
    run_op(0, MDU_OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           "div_neg7by2", 1'b0, bn, rn);

    run_op(0, MDU_OP_DIVU, 32'd100, 32'h0, 2, 32'd100, 32'hFFFF_FFFF,
           "divu_by0_fast", 1'b0, bn, rn);
    check("divu_by0_fast busy cycles", bn, 1);
    wait_nf_idle();
    run_op(1, MDU_OP_DIVU, 32'd100, 32'h0, 34, 32'd100, 32'hFFFF_FFFF,
           "divu_by0_slow", 1'b0, bn, rn);

    run_op(0, MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000,
           "div_min_by_m1", 1'b0, bn, rn);

    run_op(0, MDU_OP_DIV, 32'hFFFF_FFFB, 32'h0, 2, 32'hFFFF_FFFB, 32'hFFFF_FFFF,
           "div_neg_by0_fast", 1'b0, bn, rn);
    wait_nf_idle();
    run_op(0, MDU_OP_MULT, 32'h0, 32'hFFFF_FFFB, 2, 32'h0, 32'h0,
           "mult_zero_fast", 1'b0, bn, rn);
    wait_nf_idle();

    // Flush: preload HI/LO, start a divide, abort it in cycle T+10.
    hi_we    = 1'b1;
    mt_wdata = 32'h11;
    @(negedge clk);
    hi_we    = 1'b0;
    lo_we    = 1'b1;
    mt_wdata = 32'h22;
    @(negedge clk);
    lo_we    = 1'b0;
    check("mthi preload", f_hi, 32'h11);
    check("mtlo preload", f_lo, 32'h22);
    req_valid = 1'b1;
    req_op    = MDU_OP_DIVU;
    src_a     = 32'd1000;
    src_b     = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("flush pre busy", f_busy, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", f_busy, 1'b0);
    check("flush ready", f_ready, 1'b1);
    check("flush nf busy", n_busy, 1'b0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (f_done || n_done) seen++;
    end
    check("flush no done", seen, 0);
    check("flush hi kept", f_hi, 32'h11);
    check("flush lo kept", f_lo, 32'h22);

    // Back-to-back: second op accepted in the done cycle of the first;
    // an MTHI pulse while busy must be dropped.
    run_op(0, MDU_OP_MULTU, 32'd6, 32'd7, 34, 32'h0, 32'd42, "multu_6x7", 1'b0, bn, rn);
    run_op(0, MDU_OP_DIVU, 32'd42, 32'd5, 34, 32'd2, 32'd8, "divu_42by5", 1'b1, bn, rn);

    // Reset in the middle of an op clears everything.
    req_valid = 1'b1;
    req_op    = MDU_OP_DIVU;
    src_a     = 32'd1000;
    src_b     = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midop reset busy", f_busy, 1'b0);
    check("midop reset hi", f_hi, 32'h0);
    check("midop reset lo", f_lo, 32'h0);
    check("midop reset nf busy", n_busy, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mdu_seq
